// File: rtl/ternary_coeff_streamer.sv
// Captures a packed ternary polynomial, arms the multiplier, then streams one 2-bit coefficient per clock.
// Optional illegal-code checking is enabled by defining STREAM_ERR_CHECK_EN.
`default_nettype none

module ternary_coeff_streamer #(
  parameter int NUM_N              = 701,
  parameter int NUM_WIDTH_LENGTH_R = 2,
  parameter int DRAIN_CYCLES       = 2
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic [NUM_N*NUM_WIDTH_LENGTH_R-1:0] r_in,
  output logic                                busy,
  output logic                                mul_en,
  output logic [1:0]                          rin,
  output logic                                rin_valid,
  output logic                                done,
  output logic                                err
);

  localparam int CW = $clog2(NUM_N + 1);
  localparam int DW = $clog2(DRAIN_CYCLES + 1);
  localparam int RW = NUM_N * NUM_WIDTH_LENGTH_R;
  localparam logic [CW-1:0] CNT_LAST   = CW'(NUM_N - 1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ARM    = 3'd1,
    S_STREAM = 3'd2,
    S_DRAIN  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]   drain_q, drain_d;
  logic [RW-1:0]   sreg_q, sreg_d;
  logic            busy_q, busy_d;
  logic            mul_en_q, mul_en_d;
  logic [1:0]      rin_q, rin_d;
  logic            rin_valid_q, rin_valid_d;
  logic            done_q, done_d;
  logic [1:0]      coef;
  logic [1:0]      coef_out;
  logic            accept;

  assign coef   = sreg_q[1:0];
  assign accept = (state_q == S_IDLE) && start;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    drain_d = drain_q;
    sreg_d  = sreg_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ARM;
          sreg_d  = r_in;
        end
      end
      S_ARM: begin
        state_d = S_STREAM;
        cnt_d   = '0;
      end
      S_STREAM: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = S_DRAIN;
          drain_d = '0;
        end
      end
      S_DRAIN: begin
        if (drain_q == DRAIN_LAST) state_d = S_DONE;
        else                       drain_d = drain_q + 1'b1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Outputs are registered from the next state, so the shift that feeds
    // coefficient k happens on the edge that enters STREAM cycle k.
    if (state_d == S_STREAM) sreg_d = sreg_q >> NUM_WIDTH_LENGTH_R;
  end

`ifdef STREAM_ERR_CHECK_EN
  logic ill_q, ill_d;
  logic err_q, err_d;

  assign coef_out = (coef == 2'b10) ? 2'b00 : coef;

  always_comb begin
    ill_d = (state_d == S_STREAM) && (coef == 2'b10);
    err_d = accept ? 1'b0 : (err_q | ill_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ill_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      ill_q <= ill_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign coef_out = coef;
  assign err      = 1'b0;
`endif

  always_comb begin
    busy_d      = (state_d != S_IDLE);
    mul_en_d    = (state_d == S_ARM);
    done_d      = (state_d == S_DONE);
    rin_valid_d = (state_d == S_STREAM);
    rin_d       = rin_valid_d ? coef_out : 2'b00;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      drain_q     <= '0;
      sreg_q      <= '0;
      busy_q      <= 1'b0;
      mul_en_q    <= 1'b0;
      rin_q       <= 2'b00;
      rin_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      drain_q     <= drain_d;
      sreg_q      <= sreg_d;
      busy_q      <= busy_d;
      mul_en_q    <= mul_en_d;
      rin_q       <= rin_d;
      rin_valid_q <= rin_valid_d;
      done_q      <= done_d;
    end
  end

  assign busy      = busy_q;
  assign mul_en    = mul_en_q;
  assign rin       = rin_q;
  assign rin_valid = rin_valid_q;
  assign done      = done_q;

endmodule

`default_nettype wire

// File: tb/tb_ternary_coeff_streamer.sv
// Directed self-checking bench for ternary_coeff_streamer (NUM_N=701, DRAIN_CYCLES=2).
`default_nettype none

module tb_ternary_coeff_streamer;

  localparam int N  = 701;
  localparam int DR = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [2*N-1:0] r_in;
  logic           busy, mul_en, rin_valid, done, err;
  logic [1:0]     rin;

  int tests = 0;
  int fails = 0;
  logic [1:0] got [N];

  logic [2*N-1:0] vpat, vrev, vbad;

  ternary_coeff_streamer #(
    .NUM_N(N), .NUM_WIDTH_LENGTH_R(2), .DRAIN_CYCLES(DR)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .r_in(r_in),
    .busy(busy), .mul_en(mul_en), .rin(rin), .rin_valid(rin_valid),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full transaction; abort_k >= 0 asserts rst during that STREAM cycle.
  task automatic run(input logic [2*N-1:0] vec, input bit hammer, input int abort_k);
    int bad_cyc, bad_err, first_bad, done_seen;
    logic exp_err;
    logic [1:0] raw, exp_rin;
    bad_cyc = 0; bad_err = 0; first_bad = -1; done_seen = 0; exp_err = 1'b0;
    r_in  = vec;
    start = 1'b1;
    @(negedge clk);
    start = hammer;
    r_in  = ~vec;
    chk("arm", {25'd0, mul_en, busy, rin_valid, done, rin, err}, 32'b1100000);
    for (int k = 0; k < N; k++) begin
      start = hammer;
      @(negedge clk);
      if (k == abort_k) begin
        #2 rst = 1'b1;
        #1;
        chk("abort_outputs", {25'd0, mul_en, busy, rin_valid, done, rin, err}, 32'd0);
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        for (int c = 0; c < N + DR + 4; c++) begin
          @(negedge clk);
          if (done || busy) done_seen++;
        end
        chk("abort_no_done", done_seen, 0);
        return;
      end
      got[k]  = rin;
      raw     = vec[2*k +: 2];
      exp_rin = raw;
`ifdef STREAM_ERR_CHECK_EN
      if (raw == 2'b10) exp_rin = 2'b00;
      if (err !== exp_err) bad_err++;
      if (raw == 2'b10) exp_err = 1'b1;
`else
      if (err !== 1'b0) bad_err++;
`endif
      if (rin !== exp_rin || rin_valid !== 1'b1 || mul_en !== 1'b0 || done !== 1'b0 || busy !== 1'b1) begin
        bad_cyc++;
        if (first_bad < 0) first_bad = k;
      end
    end
    start = 1'b0;
    chk($sformatf("stream_bad_cycles_first_%0d", first_bad), bad_cyc, 0);
    chk("stream_err", bad_err, 0);
    for (int d = 0; d < DR; d++) begin
      @(negedge clk);
      chk("drain", {27'd0, busy, rin_valid, done, rin}, 32'b10000);
    end
    @(negedge clk);
    chk("done_pulse", {29'd0, busy, done, rin_valid}, 32'b110);
    if (hammer) start = 1'b1;
    @(negedge clk);
    chk("idle_after_done", {29'd0, busy, done, mul_en}, 32'd0);
    start = 1'b0;
    @(negedge clk);
    chk("no_restart", {30'd0, busy, mul_en}, 32'd0);
    chk("err_end", {31'd0, err}, {31'd0, exp_err});
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      vpat[2*i +: 2] = (i % 3 == 0) ? 2'b01 : (i % 3 == 1) ? 2'b11 : 2'b00;
      vrev[2*i +: 2] = (i % 3 == 0) ? 2'b11 : (i % 3 == 1) ? 2'b00 : 2'b01;
    end
    vbad = vpat;
    vbad[11:10] = 2'b10;

    rst = 1'b1; start = 1'b0; r_in = '0;
    #2;
    chk("reset_outputs", {25'd0, busy, mul_en, rin_valid, done, rin, err}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_no_start", {29'd0, busy, mul_en, rin_valid}, 32'd0);

    run(vpat, 1'b0, -1);
    chk("pat_c0", {30'd0, got[0]}, 32'b01);
    chk("pat_c1", {30'd0, got[1]}, 32'b11);
    chk("pat_c2", {30'd0, got[2]}, 32'b00);
    chk("pat_c3", {30'd0, got[3]}, 32'b01);
    chk("pat_c700", {30'd0, got[700]}, 32'b11);

    run(vpat, 1'b1, -1);

    run(vpat, 1'b0, 300);
    run(vrev, 1'b0, -1);
    chk("fresh_c0", {30'd0, got[0]}, 32'b11);
    chk("fresh_c1", {30'd0, got[1]}, 32'b00);
    chk("fresh_c2", {30'd0, got[2]}, 32'b01);

    run(vbad, 1'b0, -1);
`ifdef STREAM_ERR_CHECK_EN
    chk("bad_c5", {30'd0, got[5]}, 32'b00);
    chk("bad_err_sticky", {31'd0, err}, 32'd1);
`else
    chk("bad_c5", {30'd0, got[5]}, 32'b10);
    chk("bad_err_sticky", {31'd0, err}, 32'd0);
`endif
    chk("bad_c4", {30'd0, got[4]}, 32'b11);
    chk("bad_c6", {30'd0, got[6]}, 32'b01);

    run(vpat, 1'b0, -1);
    chk("clean_c5", {30'd0, got[5]}, 32'b00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
